// File: rtl/lynxTypes.sv
// Shared shell types: stream/PID widths plus the route tagger's destination count and FSM states.
package lynxTypes;

    localparam int PID_BITS      = 6;
    localparam int AXI_DATA_BITS = 512;
    localparam int N_REGIONS     = 1;
    localparam int VIO_N_DEST    = 14;

    typedef enum logic [1:0] {VT_IDLE, VT_FWD, VT_DROP} vt_state_t;

endpackage

// File: rtl/vio_route_tagger_slice.sv
// Two-entry skid register slice: one output register plus one overflow register.
// The input-side ready depends only on local state, so no combinational path runs from m_ready.
module vio_axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_payload,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_payload
);

    logic         skid_valid;
    logic [W-1:0] skid_payload;

    assign s_ready = !skid_valid;

    // The skid entry only fills when the output is stalled; it drains first once m_ready returns.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid      <= 1'b0;
            m_payload    <= '0;
            skid_valid   <= 1'b0;
            skid_payload <= '0;
        end else if (skid_valid) begin
            if (m_ready) begin
                m_payload  <= skid_payload;
                skid_valid <= 1'b0;
            end
        end else if (m_valid && !m_ready) begin
            if (s_valid) begin
                skid_payload <= s_payload;
                skid_valid   <= 1'b1;
            end
        end else begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_payload <= s_payload;
            end
        end
    end

endmodule

// File: rtl/vio_route_tagger.sv
// Ingress tagger: looks up a per-PID route on the first beat of each packet, holds it as tdest
// for the whole packet, drops packets with an empty route, and counts forwarded/dropped packets.
module vio_route_tagger #(
    parameter int N_DEST    = lynxTypes::VIO_N_DEST,
    parameter int PID_BITS  = lynxTypes::PID_BITS,
    parameter int DATA_BITS = lynxTypes::AXI_DATA_BITS,
    parameter int CNT_BITS  = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cfg_we,
    input  logic [PID_BITS-1:0]    cfg_addr,
    input  logic [N_DEST-1:0]      cfg_route,
    input  logic                   cfg_clr,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic [PID_BITS-1:0]    s_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic [PID_BITS-1:0]    m_axis_tid,
    output logic [N_DEST-1:0]      m_axis_tdest,
    output logic [CNT_BITS-1:0]    stat_pkts,
    output logic [CNT_BITS-1:0]    stat_drops
);

    import lynxTypes::*;

    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int PAYLOAD_W = DATA_BITS + KEEP_BITS + 1 + PID_BITS + N_DEST;
    localparam int N_ENTRIES = 2 ** PID_BITS;

    logic [N_DEST-1:0]   route_tbl [N_ENTRIES];
    logic [N_DEST-1:0]   lookup;
    vt_state_t           state, state_nxt;
    logic [N_DEST-1:0]   cur_dest;
    logic [PID_BITS-1:0] cur_tid;
    logic                rst_done;
    logic                slice_ready;
    logic                push;
    logic                first_hit;
    logic                drop_done;
    logic                pkt_done;
    logic [N_DEST-1:0]   push_dest;
    logic [PID_BITS-1:0] push_tid;
    logic [PAYLOAD_W-1:0] push_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                route_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            route_tbl[cfg_addr] <= cfg_route;
        end
    end

    // Read before any same-cycle write lands, so a colliding lookup sees the old route.
    assign lookup = route_tbl[s_axis_tid];

    // Holds the input side closed until the first clock edge after reset is released.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        push          = 1'b0;
        push_dest     = cur_dest;
        push_tid      = cur_tid;
        first_hit     = 1'b0;
        drop_done     = 1'b0;
        if (rst_done) begin
            case (state)
                VT_IDLE: begin
                    if (lookup != '0) begin
                        s_axis_tready = slice_ready;
                        push          = s_axis_tvalid && slice_ready;
                        push_dest     = lookup;
                        push_tid      = s_axis_tid;
                        first_hit     = push;
                        if (push && !s_axis_tlast) state_nxt = VT_FWD;
                    end else begin
                        s_axis_tready = 1'b1;
                        if (s_axis_tvalid) begin
                            if (s_axis_tlast) drop_done = 1'b1;
                            else              state_nxt = VT_DROP;
                        end
                    end
                end
                VT_FWD: begin
                    s_axis_tready = slice_ready;
                    push          = s_axis_tvalid && slice_ready;
                    if (push && s_axis_tlast) state_nxt = VT_IDLE;
                end
                VT_DROP: begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        drop_done = 1'b1;
                        state_nxt = VT_IDLE;
                    end
                end
                default: state_nxt = VT_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= VT_IDLE;
            cur_dest <= '0;
            cur_tid  <= '0;
        end else begin
            state <= state_nxt;
            if (first_hit) begin
                cur_dest <= lookup;
                cur_tid  <= s_axis_tid;
            end
        end
    end

    assign push_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, push_tid, push_dest};

    vio_axis_reg_slice #(
        .W(PAYLOAD_W)
    ) u_slice (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_valid   (push),
        .s_ready   (slice_ready),
        .s_payload (push_payload),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready),
        .m_payload (out_payload)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest} = out_payload;

    assign pkt_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // A clear wins over a coincident increment; both counters stick at all-ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkts  <= '0;
            stat_drops <= '0;
        end else if (cfg_clr) begin
            stat_pkts  <= '0;
            stat_drops <= '0;
        end else begin
            if (pkt_done && (stat_pkts != '1))   stat_pkts  <= stat_pkts + CNT_BITS'(1);
            if (drop_done && (stat_drops != '1)) stat_drops <= stat_drops + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_vio_route_tagger.sv
// Directed bench for vio_route_tagger: forwarding, dropping, route updates, backpressure,
// counter saturation/clear and reset behaviour, checked against hand-computed values.
module tb_vio_route_tagger;

    localparam int N_DEST    = 14;
    localparam int PID_BITS  = 6;
    localparam int DATA_BITS = 32;
    localparam int CNT_BITS  = 8;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b0;
    logic                   cfg_we = 1'b0;
    logic [PID_BITS-1:0]    cfg_addr = '0;
    logic [N_DEST-1:0]      cfg_route = '0;
    logic                   cfg_clr = 1'b0;
    logic                   s_axis_tvalid = 1'b0;
    logic                   s_axis_tready;
    logic                   s_axis_tlast = 1'b0;
    logic [DATA_BITS-1:0]   s_axis_tdata = '0;
    logic [DATA_BITS/8-1:0] s_axis_tkeep = '0;
    logic [PID_BITS-1:0]    s_axis_tid = '0;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b0;
    logic                   m_axis_tlast;
    logic [DATA_BITS-1:0]   m_axis_tdata;
    logic [DATA_BITS/8-1:0] m_axis_tkeep;
    logic [PID_BITS-1:0]    m_axis_tid;
    logic [N_DEST-1:0]      m_axis_tdest;
    logic [CNT_BITS-1:0]    stat_pkts;
    logic [CNT_BITS-1:0]    stat_drops;

    typedef struct {
        logic [DATA_BITS-1:0]   data;
        logic [DATA_BITS/8-1:0] keep;
        logic [N_DEST-1:0]      dest;
        logic [PID_BITS-1:0]    tid;
        logic                   last;
    } beat_t;

    beat_t mon_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    bp_done;

    vio_route_tagger #(
        .N_DEST(N_DEST), .PID_BITS(PID_BITS), .DATA_BITS(DATA_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_route(cfg_route), .cfg_clr(cfg_clr),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tid(s_axis_tid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .stat_pkts(stat_pkts), .stat_drops(stat_drops)
    );

    always #5 aclk = ~aclk;

    // Inputs change just after posedge, so the falling edge sees exactly what the next posedge will use.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            mon_q.push_back('{data: m_axis_tdata, keep: m_axis_tkeep, dest: m_axis_tdest,
                              tid: m_axis_tid, last: m_axis_tlast});
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cfg_write(input logic [PID_BITS-1:0] addr, input logic [N_DEST-1:0] route);
        cfg_we = 1'b1;
        cfg_addr = addr;
        cfg_route = route;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic clear_stats();
        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
    endtask

    task automatic drive_beat(input logic [DATA_BITS-1:0] d, input logic [PID_BITS-1:0] id,
                              input logic last);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = d[3:0];
        s_axis_tid    = id;
        s_axis_tlast  = last;
        forever begin
            @(negedge aclk);
            if (s_axis_tready) break;
            @(posedge aclk);
            #1;
            n++;
            if (n > 500) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout got=stalled exp=accepted data=%h", d);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        idle(2);
        checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_tready got=%b exp=0", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tdest !== '0) begin failures++; $display("[TB] FAIL reset_tdest got=%h exp=0", m_axis_tdest); end
        checks++; if (stat_pkts !== '0 || stat_drops !== '0) begin failures++; $display("[TB] FAIL reset_stats got=%0d/%0d exp=0/0", stat_pkts, stat_drops); end
        aresetn = 1'b1;
        idle(2);
        checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_tready got=%b exp=1", s_axis_tready); end
    endtask

    task automatic test_forward();
        cfg_write(6'd3, 14'h0004);
        m_axis_tready = 1'b1;
        mon_q.delete();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL fwd_pre_valid got=%b exp=0", m_axis_tvalid); end
        drive_beat(32'h1000_0000, 6'd3, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdest !== 14'h0004) begin
            failures++; $display("[TB] FAIL fwd_latency got=%b/%h exp=1/0004", m_axis_tvalid, m_axis_tdest);
        end
        for (int i = 1; i < 4; i++) drive_beat(32'h1000_0000 + 32'(i), 6'd3, i == 3);
        idle(3);
        checks++; if (mon_q.size() != 4) begin failures++; $display("[TB] FAIL fwd_count got=%0d exp=4", mon_q.size()); end
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].data !== 32'h1000_0000 + 32'(i) || mon_q[i].dest !== 14'h0004 ||
                mon_q[i].tid !== 6'd3 || mon_q[i].last !== (i == 3) || mon_q[i].keep !== 4'(i)) begin
                failures++;
                $display("[TB] FAIL fwd_beat%0d got=%h/%h/%0d/%b exp=%h/0004/3/%b", i, mon_q[i].data,
                         mon_q[i].dest, mon_q[i].tid, mon_q[i].last, 32'h1000_0000 + 32'(i), i == 3);
            end
        end
        checks++; if (stat_pkts !== 8'd1) begin failures++; $display("[TB] FAIL fwd_stat_pkts got=%0d exp=1", stat_pkts); end
    endtask

    task automatic test_drop();
        mon_q.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h5000_0000 + 32'(i);
            s_axis_tkeep  = 4'hF;
            s_axis_tid    = 6'd5;
            s_axis_tlast  = (i == 2);
            @(negedge aclk);
            checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("[TB] FAIL drop_tready%0d got=%b exp=1", i, s_axis_tready); end
            checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL drop_mvalid%0d got=%b exp=0", i, m_axis_tvalid); end
            step();
        end
        s_axis_tvalid = 1'b0;
        idle(2);
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL drop_mvalid_end got=%b exp=0", m_axis_tvalid); end
        checks++; if (stat_drops !== 8'd1) begin failures++; $display("[TB] FAIL drop_stat got=%0d exp=1", stat_drops); end
        m_axis_tready = 1'b1;
        idle(1);
    endtask

    task automatic test_table_update();
        logic [N_DEST-1:0]    exp_dest [6] = '{14'h0004, 14'h0004, 14'h0004, 14'h0004, 14'h2000, 14'h2000};
        logic                 exp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [DATA_BITS-1:0] exp_data [6] = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2100, 32'h2101};
        mon_q.delete();
        drive_beat(32'h2000, 6'd3, 1'b0);
        cfg_we = 1'b1;
        cfg_addr = 6'd3;
        cfg_route = 14'h2000;
        drive_beat(32'h2001, 6'd3, 1'b0);
        cfg_we = 1'b0;
        drive_beat(32'h2002, 6'd7, 1'b0);
        drive_beat(32'h2003, 6'd3, 1'b1);
        drive_beat(32'h2100, 6'd3, 1'b0);
        drive_beat(32'h2101, 6'd3, 1'b1);
        idle(3);
        checks++; if (mon_q.size() != 6) begin failures++; $display("[TB] FAIL upd_count got=%0d exp=6", mon_q.size()); end
        for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].data !== exp_data[i] || mon_q[i].dest !== exp_dest[i] ||
                mon_q[i].tid !== 6'd3 || mon_q[i].last !== exp_last[i]) begin
                failures++;
                $display("[TB] FAIL upd_beat%0d got=%h/%h/%0d/%b exp=%h/%h/3/%b", i, mon_q[i].data,
                         mon_q[i].dest, mon_q[i].tid, mon_q[i].last, exp_data[i], exp_dest[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        for (int i = 0; i < 8; i++) cfg_write(6'(i), 14'(1 << i));
        clear_stats();
        mon_q.delete();
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) drive_beat(32'hA000_0000 + 32'(i), 6'(i % 8), 1'b1);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    m_axis_tready = 1'($urandom_range(0, 1));
                    step();
                end
                m_axis_tready = 1'b1;
            end
        join
        while (mon_q.size() < 100 && n < 1000) begin
            step();
            n++;
        end
        idle(2);
        checks++; if (mon_q.size() != 100) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=100", mon_q.size()); end
        for (int i = 0; i < 100 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].data !== 32'hA000_0000 + 32'(i) || mon_q[i].dest !== 14'(1 << (i % 8)) ||
                mon_q[i].tid !== 6'(i % 8) || mon_q[i].last !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_beat%0d got=%h/%h/%0d exp=%h/%h/%0d", i, mon_q[i].data,
                         mon_q[i].dest, mon_q[i].tid, 32'hA000_0000 + 32'(i), 14'(1 << (i % 8)), i % 8);
            end
        end
        checks++; if (stat_pkts !== 8'd100) begin failures++; $display("[TB] FAIL b2b_stat_pkts got=%0d exp=100", stat_pkts); end
    endtask

    task automatic test_saturation();
        clear_stats();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 255; i++) drive_beat(32'(i), 6'd0, 1'b1);
        idle(3);
        checks++; if (stat_pkts !== 8'hFF) begin failures++; $display("[TB] FAIL sat_reach got=%0d exp=255", stat_pkts); end
        drive_beat(32'h0000_0100, 6'd0, 1'b1);
        idle(3);
        checks++; if (stat_pkts !== 8'hFF) begin failures++; $display("[TB] FAIL sat_hold got=%0d exp=255", stat_pkts); end
        drive_beat(32'h0000_0101, 6'd0, 1'b1);
        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
        checks++; if (stat_pkts !== 8'd0) begin failures++; $display("[TB] FAIL clr_vs_pkt got=%0d exp=0", stat_pkts); end
        cfg_clr = 1'b1;
        drive_beat(32'h0000_0102, 6'd9, 1'b1);
        cfg_clr = 1'b0;
        checks++; if (stat_drops !== 8'd0) begin failures++; $display("[TB] FAIL clr_vs_drop got=%0d exp=0", stat_drops); end
        drive_beat(32'h0000_0103, 6'd9, 1'b1);
        checks++; if (stat_drops !== 8'd1) begin failures++; $display("[TB] FAIL drop_after_clr got=%0d exp=1", stat_drops); end
    endtask

    task automatic test_reset_midpacket();
        m_axis_tready = 1'b1;
        drive_beat(32'h3000, 6'd0, 1'b0);
        drive_beat(32'h3001, 6'd0, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h3002;
        aresetn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_outputs got=%b/%b exp=0/0", m_axis_tvalid, s_axis_tready);
        end
        step();
        checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdest !== '0) begin
            failures++; $display("[TB] FAIL midrst_hold got=%b/%b/%h exp=0/0/0", m_axis_tvalid, s_axis_tready, m_axis_tdest);
        end
        s_axis_tvalid = 1'b0;
        aresetn = 1'b1;
        idle(2);
        mon_q.delete();
        drive_beat(32'h3100, 6'd0, 1'b0);
        drive_beat(32'h3101, 6'd0, 1'b1);
        idle(3);
        checks++; if (mon_q.size() != 0) begin failures++; $display("[TB] FAIL midrst_forwarded got=%0d exp=0", mon_q.size()); end
        checks++; if (stat_drops !== 8'd1) begin failures++; $display("[TB] FAIL midrst_drops got=%0d exp=1", stat_drops); end
        checks++; if (stat_pkts !== 8'd0) begin failures++; $display("[TB] FAIL midrst_pkts got=%0d exp=0", stat_pkts); end
    endtask

    initial begin
        $display("[TB] starting vio_route_tagger bench");
        test_reset();
        test_forward();
        test_drop();
        test_table_update();
        test_back_to_back();
        test_saturation();
        test_reset_midpacket();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vio_route_tagger.md
Name: vio_route_tagger

Overview:
- Per-region ingress tagger between a vFPGA user stream and its sink port on the 14-output vFPGA data switch.
- Each packet gets a 14-bit one-hot/multicast tdest from a host-programmed route table indexed by the packet's PID (tid).
- tdest is held stable for the whole packet, as the switch requires. Packets whose route is zero are drained and dropped.
- Packet and drop statistics are kept for the shell CSR block.

Parameters:
- N_DEST, 14, width of the switch tdest (number of switch destinations)
- PID_BITS, lynxTypes::PID_BITS, tid width; route table has 2**PID_BITS entries
- DATA_BITS, lynxTypes::AXI_DATA_BITS, stream data width
- CNT_BITS, 32, statistics counter width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cfg_we  in  1  route table write strobe
- cfg_addr  in  PID_BITS  table index
- cfg_route  in  N_DEST  route mask written
- cfg_clr  in  1  clears statistics counters
- s_axis_tvalid/tready/tlast  in/out/in  1  user-side stream handshake
- s_axis_tdata  in  DATA_BITS  payload
- s_axis_tkeep  in  DATA_BITS/8  byte enables
- s_axis_tid  in  PID_BITS  packet PID, sampled on the first beat only
- m_axis_tvalid/tready/tlast  out/in/out  1  switch-side stream handshake
- m_axis_tdata  out  DATA_BITS  payload
- m_axis_tkeep  out  DATA_BITS/8  byte enables
- m_axis_tid  out  PID_BITS  latched packet PID
- m_axis_tdest  out  N_DEST  latched route, drives the switch route_in
- stat_pkts  out  CNT_BITS  packets forwarded (counted on tlast handshake at m side)
- stat_drops  out  CNT_BITS  packets dropped (counted on tlast accept in DROP)

Behaviour:
- Reset (async assert, sync deassert via aclk): table entries=0, state=IDLE, m_axis_tvalid=0, m_axis_tdest/tid/tdata/tkeep/tlast=0, stats=0, s_axis_tready=0 during reset.
- Route table: registered array, write on cfg_we at aclk edge. A lookup in the same cycle as a write to the same address returns the OLD value.
- FSM states:
  - IDLE: waiting for a first beat. On s_axis_tvalid, route=table[s_axis_tid].
    - route!=0: beat accepted when the slice has room; tdest/tid latched. If tlast stay IDLE, else go to FWD.
    - route==0: beat accepted unconditionally (s_axis_tready=1) and discarded. If tlast: stat_drops++ and stay IDLE, else go to DROP.
  - FWD: beats pass with the latched tdest/tid; s_axis_tid is ignored. On the accepted tlast beat, go to IDLE.
  - DROP: s_axis_tready=1, beats discarded. On tlast: stat_drops++, go to IDLE.
- Output via a 2-entry skid register slice:
  - Latency 1 cycle from s accept to m_axis_tvalid.
  - Full throughput: 1 beat/cycle with m_axis_tready=1.
  - s_axis_tready = slice not full in IDLE(route!=0)/FWD.
  - m_axis_* stable while tvalid && !tready.
- Table writes during FWD do not alter the in-flight packet; they take effect on the next first beat.
- cfg_clr zeros both counters next cycle. If cfg_clr coincides with an increment, the result is 0.
- Counters saturate at all-ones; no wrap.
- tdest is latched per packet, not per beat. A tid change mid-packet has no effect.
- m_axis_tdest is never 0 while m_axis_tvalid=1.

Decomposition:
- lynxTypes holds PID_BITS, AXI_DATA_BITS and N_REGIONS.
- Add to lynxTypes: localparam VIO_N_DEST=14 and typedef enum logic [1:0] {VT_IDLE, VT_FWD, VT_DROP} vt_state_t.
- Sub-module vio_axis_reg_slice: 2-entry skid buffer carrying {tdata, tkeep, tlast, tid, tdest}, with parameterised payload width.

Test Plan:
- Write table[3]=14'h0004; send a 4-beat packet with tid=3 -> 4 m beats, tdest=0x0004 and tid=3 on every beat, first m_axis_tvalid 1 cycle after first accept; stat_pkts=1.
- table[5]=0; send a 3-beat packet with tid=5, m_axis_tready=0 -> s_axis_tready=1 throughout, no m_axis_tvalid, stat_drops=1.
- Mid-FWD of a tid=3 packet, write table[3]=0x2000 -> rest of packet keeps tdest=0x0004; the next tid=3 packet carries 0x2000.
- Random m_axis_tready backpressure (50%), 100 back-to-back 1-beat packets across tid 0..7 with distinct routes -> no beat lost or duplicated, data order preserved, tdest per packet matches table, stat_pkts=100.
- Assert aresetn=0 mid-packet, release, send a fresh packet -> m_axis_tvalid=0 during reset, table cleared so the packet is dropped, stat_drops=1, stat_pkts=0.
- Preload stat_pkts to all-ones via forced increments -> one more packet leaves it at all-ones; cfg_clr in the same cycle as a tlast -> counter reads 0.
